// File: rtl/data_memory_io.sv
// Data-bus responder: word RAM plus a memory-mapped I/O page (TX FIFO, synchronized input, status).
// Define DATA_MEMORY_CYCLE_COUNTER_EN to build the free-running cycle counter at I/O offset 3.
module data_memory_io #(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          IN_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address,
  input  logic                mem_write,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [IN_WIDTH-1:0] in_data
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

  logic        is_ram;
  logic        is_io;
  logic [1:0]  offset;
  logic        wr_en;

  assign is_ram = (address < RAM_BYTES);
  assign is_io  = (address[31:4] == IO_BASE[31:4]);
  assign offset = address[3:2];
  // Writes are suppressed during reset, including RAM stores.
  assign wr_en  = mem_write & ~rst;

  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en && is_ram)
      ram[address[RAM_AW+1:2]] <= write_data;
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          status_wr;

  assign full      = (count == DEPTH);
  assign pop       = out_valid & out_ready;
  assign push_req  = wr_en & is_io & (offset == 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);
  assign status_wr = wr_en & is_io & (offset == 2'd1);

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
      if (status_wr)
        overflow <= 1'b0;
      else if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];

  logic [IN_WIDTH-1:0] sync_meta;
  logic [IN_WIDTH-1:0] sync_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_data <= '0;
    end else begin
      sync_meta <= in_data;
      sync_data <= sync_meta;
    end
  end

  logic [31:0] cycle_value;

`ifdef DATA_MEMORY_CYCLE_COUNTER_EN
  logic [31:0] cycle_count;

  always_ff @(posedge clk) begin
    if (rst)
      cycle_count <= '0;
    else if (wr_en && is_io && offset == 2'd3)
      cycle_count <= write_data;
    else
      cycle_count <= cycle_count + 32'd1;
  end

  assign cycle_value = cycle_count;
`else
  assign cycle_value = 32'd0;
`endif

  logic [31:0] status;
  logic [31:0] in_ext;
  logic [7:0]  count_ext;

  always_comb begin
    count_ext           = '0;
    count_ext[CW-1:0]   = count;
    status              = '0;
    status[0]           = ~out_valid;
    status[1]           = full;
    status[2]           = overflow;
    status[15:8]        = count_ext;
    in_ext              = '0;
    in_ext[IN_WIDTH-1:0] = sync_data;
  end

  always_comb begin
    read_data = '0;
    if (is_ram) begin
      read_data = ram[address[RAM_AW+1:2]];
    end else if (is_io) begin
      case (offset)
        2'd1:    read_data = status;
        2'd2:    read_data = in_ext;
        2'd3:    read_data = cycle_value;
        default: read_data = '0;
      endcase
    end
  end

endmodule
